// File: rtl/reg_writeback_arbiter_if.sv
// Bundle of the writeback-side signals of reg_writeback_arbiter.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: the writeback stage, the long-latency units, the
// issue stage and the register file write port.
interface reg_writeback_arbiter_if #(
    parameter int WIDTH         = 32,
    parameter int LOG2NUMREGS   = 5,
    parameter int LOG2FIFODEPTH = 2
);
    // Pipeline writeback stream
    logic [LOG2NUMREGS-1:0]   p_reg;
    logic [WIDTH-1:0]         p_data;
    logic                     p_we;
    logic                     p_squashn;

    // Long-latency return stream
    logic [LOG2NUMREGS-1:0]   l_reg;
    logic [WIDTH-1:0]         l_data;
    logic                     l_valid;
    logic                     l_ready;

    // Issue-stage scoreboard access
    logic [LOG2NUMREGS-1:0]   issue_reg;
    logic                     issue_en;
    logic [LOG2NUMREGS-1:0]   a_reg;
    logic [LOG2NUMREGS-1:0]   b_reg;
    logic                     a_pending;
    logic                     b_pending;

    // Register file write port and status
    logic [LOG2NUMREGS-1:0]   c_reg;
    logic [WIDTH-1:0]         c_writedatain;
    logic                     c_we;
    logic [LOG2FIFODEPTH:0]   fifo_count;
    logic                     waw_err;

    modport slave (
        input  p_reg, p_data, p_we, p_squashn,
        input  l_reg, l_data, l_valid,
        input  issue_reg, issue_en, a_reg, b_reg,
        output l_ready, a_pending, b_pending,
        output c_reg, c_writedatain, c_we, fifo_count, waw_err
    );

    modport master (
        output p_reg, p_data, p_we, p_squashn,
        output l_reg, l_data, l_valid,
        output issue_reg, issue_en, a_reg, b_reg,
        input  l_ready, a_pending, b_pending,
        input  c_reg, c_writedatain, c_we, fifo_count, waw_err
    );
endinterface

// File: rtl/reg_writeback_arbiter.sv
// Register-file write-port arbiter.
// The pipeline writeback always wins the write port. Long-latency returns
// wait in a small circular FIFO and drain whenever the pipeline is idle.
// A per-register pending scoreboard lets the issue stage stall reads of
// registers that still have a long-latency write outstanding.
module reg_writeback_arbiter #(
    parameter int WIDTH         = 32,
    parameter int NUMREGS       = 32,
    parameter int LOG2NUMREGS   = 5,
    parameter int FIFODEPTH     = 4,
    parameter int LOG2FIFODEPTH = 2
) (
    input  logic clk,
    input  logic resetn,
    reg_writeback_arbiter_if.slave bus
);
    typedef struct packed {
        logic [LOG2NUMREGS-1:0] rg;
        logic [WIDTH-1:0]       data;
    } entry_t;

    localparam logic [LOG2FIFODEPTH:0]   CNT_ONE  = 1;
    localparam logic [LOG2FIFODEPTH:0]   CNT_FULL = (LOG2FIFODEPTH+1)'(FIFODEPTH);
    localparam logic [LOG2FIFODEPTH-1:0] PTR_ONE  = 1;

    entry_t                   r_mem [FIFODEPTH];
    logic [LOG2FIFODEPTH-1:0] r_wr_ptr;
    logic [LOG2FIFODEPTH-1:0] r_rd_ptr;
    logic [LOG2FIFODEPTH:0]   r_count;

    logic [LOG2NUMREGS-1:0]   r_c_reg;
    logic [WIDTH-1:0]         r_c_data;
    logic                     r_c_we;
    logic                     r_waw_err;

    logic [NUMREGS-1:0]       r_sb;
    logic                     r_clr_valid;
    logic [LOG2NUMREGS-1:0]   r_clr_reg;

    logic                     w_p_acc;
    logic                     w_l_ready;
    logic                     w_push;
    logic                     w_pop;
    entry_t                   w_head;
    logic [NUMREGS-1:0]       w_sb_next;

    // Handshake and arbitration decisions; readiness uses only the registered count
    assign w_p_acc   = bus.p_we & bus.p_squashn & (|bus.p_reg);
    assign w_l_ready = (r_count != CNT_FULL);
    assign w_push    = bus.l_valid & w_l_ready & (|bus.l_reg);
    assign w_pop     = ~w_p_acc & (|r_count);
    assign w_head    = r_mem[r_rd_ptr];

    // Return buffer storage
    // NOTE: storage is deliberately not reset; only the pointers and count
    // define which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{rg: bus.l_reg, data: bus.l_data};
        end
    end

    // Buffer pointers and occupancy; pointers wrap naturally at FIFODEPTH
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered write port: pipeline first, then the buffer head
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_c_we    <= 1'b0;
            r_c_reg   <= '0;
            r_c_data  <= '0;
            r_waw_err <= 1'b0;
        end else begin
            if (w_p_acc) begin
                r_c_we   <= 1'b1;
                r_c_reg  <= bus.p_reg;
                r_c_data <= bus.p_data;
            end else if (w_pop) begin
                r_c_we   <= 1'b1;
                r_c_reg  <= w_head.rg;
                r_c_data <= w_head.data;
            end else begin
                r_c_we   <= 1'b0;
            end
            r_waw_err <= w_p_acc & r_sb[bus.p_reg];
        end
    end

    // Delay the scoreboard clear one cycle past the write: the register file
    // returns old data on a same-edge read/write, so the bit must stay set
    // through the cycle in which c_we is asserted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_clr_valid <= 1'b0;
            r_clr_reg   <= '0;
        end else begin
            r_clr_valid <= w_pop;
            r_clr_reg   <= w_head.rg;
        end
    end

    // Next scoreboard value: a set on the same register overrides the clear
    always_comb begin
        // NOTE: the default assignment comes first so no path leaves
        // w_sb_next unassigned, which would otherwise infer a latch.
        w_sb_next = r_sb;
        if (r_clr_valid)  w_sb_next[r_clr_reg]     = 1'b0;
        if (bus.issue_en) w_sb_next[bus.issue_reg] = 1'b1;
        w_sb_next[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_next;
        end
    end

    assign bus.l_ready       = w_l_ready;
    assign bus.a_pending     = r_sb[bus.a_reg];
    assign bus.b_pending     = r_sb[bus.b_reg];
    assign bus.c_reg         = r_c_reg;
    assign bus.c_writedatain = r_c_data;
    assign bus.c_we          = r_c_we;
    assign bus.fifo_count    = r_count;
    assign bus.waw_err       = r_waw_err;
endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Self-checking bench for reg_writeback_arbiter. Expected register-file
// writes are queued as stimulus is applied and compared in order whenever
// the write port fires; directed checks cover timing and scoreboard rules.
module tb_reg_writeback_arbiter;
    localparam int WIDTH         = 32;
    localparam int NUMREGS       = 32;
    localparam int LOG2NUMREGS   = 5;
    localparam int FIFODEPTH     = 4;
    localparam int LOG2FIFODEPTH = 2;

    typedef struct {
        logic [LOG2NUMREGS-1:0] rg;
        logic [WIDTH-1:0]       data;
    } wr_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    reg_writeback_arbiter_if #(
        .WIDTH(WIDTH), .LOG2NUMREGS(LOG2NUMREGS), .LOG2FIFODEPTH(LOG2FIFODEPTH)
    ) bus ();

    reg_writeback_arbiter #(
        .WIDTH(WIDTH), .NUMREGS(NUMREGS), .LOG2NUMREGS(LOG2NUMREGS),
        .FIFODEPTH(FIFODEPTH), .LOG2FIFODEPTH(LOG2FIFODEPTH)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int  n_checks = 0;
    int  n_fail   = 0;
    wr_t exp_q[$];
    wr_t m_fifo[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.p_we      = 1'b0;
        bus.p_squashn = 1'b1;
        bus.p_reg     = '0;
        bus.p_data    = '0;
        bus.l_valid   = 1'b0;
        bus.l_reg     = '0;
        bus.l_data    = '0;
        bus.issue_en  = 1'b0;
        bus.issue_reg = '0;
    endtask

    // Model the current cycle from the driven inputs, then advance to #1 after the edge
    task automatic step();
        bit  p_acc;
        bit  m_ready;
        wr_t e;
        p_acc   = bus.p_we && bus.p_squashn && (bus.p_reg != 0);
        m_ready = (m_fifo.size() < FIFODEPTH);
        check("l_ready", bus.l_ready, m_ready);
        check("fifo_count", bus.fifo_count, m_fifo.size());
        if (p_acc) begin
            e.rg = bus.p_reg; e.data = bus.p_data;
            exp_q.push_back(e);
        end else if (m_fifo.size() != 0) begin
            exp_q.push_back(m_fifo.pop_front());
        end
        if (bus.l_valid && m_ready && bus.l_reg != 0) begin
            e.rg = bus.l_reg; e.data = bus.l_data;
            m_fifo.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Write-port monitor: every write must match the next expected one
    always @(negedge clk) begin
        if (resetn === 1'b1 && bus.c_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", bus.c_we, 1'b0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_reg", bus.c_reg, e.rg);
                check("wr_data", bus.c_writedatain, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        idle();
        bus.a_reg = 5'd5;
        bus.b_reg = 5'd31;
        repeat (3) @(posedge clk);
        #1;
        check("rst_c_we", bus.c_we, 1'b0);
        check("rst_c_reg", bus.c_reg, 0);
        check("rst_c_data", bus.c_writedatain, 0);
        check("rst_count", bus.fifo_count, 0);
        check("rst_waw", bus.waw_err, 1'b0);
        check("rst_l_ready", bus.l_ready, 1'b1);
        check("rst_a_pend", bus.a_pending, 1'b0);
        check("rst_b_pend", bus.b_pending, 1'b0);
        resetn = 1'b1;
        step();

        // Basic pipeline write: visible for exactly one cycle
        bus.p_we = 1'b1; bus.p_reg = 5'd5; bus.p_data = 32'hDEADBEEF;
        step();
        idle();
        check("pw_c_we", bus.c_we, 1'b1);
        check("pw_c_reg", bus.c_reg, 5);
        check("pw_c_data", bus.c_writedatain, 32'hDEADBEEF);
        step();
        check("pw_c_we_off", bus.c_we, 1'b0);

        // Writes to r0, squashed writes and r0 returns are all dropped
        bus.p_we = 1'b1; bus.p_reg = 5'd0; bus.p_data = 32'h11111111;
        step();
        idle();
        check("r0_no_we", bus.c_we, 1'b0);
        bus.p_we = 1'b1; bus.p_squashn = 1'b0; bus.p_reg = 5'd7; bus.p_data = 32'h77;
        step();
        idle();
        check("squash_no_we", bus.c_we, 1'b0);
        bus.l_valid = 1'b1; bus.l_reg = 5'd0; bus.l_data = 32'h55;
        step();
        idle();
        check("l_r0_count", bus.fifo_count, 0);
        step();
        check("l_r0_no_we", bus.c_we, 1'b0);

        // Scoreboard set, return latency and delayed clear
        bus.issue_en = 1'b1; bus.issue_reg = 5'd9; bus.a_reg = 5'd9;
        step();
        idle();
        #1 check("sb9_set", bus.a_pending, 1'b1);
        step();
        bus.l_valid = 1'b1; bus.l_reg = 5'd9; bus.l_data = 32'h1234;
        step();
        idle();
        check("ret_n1_no_we", bus.c_we, 1'b0);
        step();
        check("ret_n2_we", bus.c_we, 1'b1);
        check("ret_n2_reg", bus.c_reg, 9);
        check("sb9_still", bus.a_pending, 1'b1);
        step();
        check("sb9_clear", bus.a_pending, 1'b0);

        // Fill the buffer under pipeline pressure, then drain in order
        for (int i = 0; i < 4; i++) begin
            bus.p_we = 1'b1; bus.p_squashn = 1'b1;
            bus.p_reg = 5'(20 + i); bus.p_data = 32'hC000 + i;
            bus.l_valid = 1'b1; bus.l_reg = 5'(10 + i); bus.l_data = 32'hA0 + i;
            step();
        end
        idle();
        check("full_count", bus.fifo_count, 4);
        check("full_l_ready", bus.l_ready, 1'b0);
        step();
        check("pop1_l_ready", bus.l_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("drain_we", bus.c_we, 1'b1);
            check("drain_reg", bus.c_reg, 10 + i);
            step();
        end
        check("drain_done_we", bus.c_we, 1'b0);

        // WAW detection: write still happens, scoreboard bit survives
        bus.issue_en = 1'b1; bus.issue_reg = 5'd3;
        step();
        idle();
        bus.p_we = 1'b1; bus.p_reg = 5'd3; bus.p_data = 32'h33;
        step();
        idle();
        bus.a_reg = 5'd3; bus.b_reg = 5'd3;
        bus.p_we = 1'b1; bus.p_reg = 5'd4; bus.p_data = 32'h44;
        #1;
        check("waw_pulse", bus.waw_err, 1'b1);
        check("waw_c_we", bus.c_we, 1'b1);
        check("waw_a_pend", bus.a_pending, 1'b1);
        check("waw_b_pend", bus.b_pending, 1'b1);
        step();
        idle();
        check("waw_off", bus.waw_err, 1'b0);
        check("waw_next_we", bus.c_we, 1'b1);
        check("waw_sb_kept", bus.a_pending, 1'b1);
        step();

        // Asynchronous reset with two buffered entries
        bus.issue_en = 1'b1; bus.issue_reg = 5'd12;
        step();
        for (int i = 0; i < 2; i++) begin
            idle();
            bus.p_we = 1'b1; bus.p_reg = 5'(21 + i); bus.p_data = 32'hB000 + i;
            bus.l_valid = 1'b1; bus.l_reg = 5'(13 + i); bus.l_data = 32'hD0 + i;
            step();
        end
        idle();
        bus.p_we = 1'b1; bus.p_reg = 5'd23; bus.p_data = 32'hB002;
        bus.a_reg = 5'd12;
        #1;
        check("pre_rst_count", bus.fifo_count, 2);
        check("pre_rst_pend", bus.a_pending, 1'b1);
        #1;
        resetn = 1'b0;
        exp_q.delete();
        m_fifo.delete();
        #1;
        check("mid_rst_c_we", bus.c_we, 1'b0);
        check("mid_rst_c_reg", bus.c_reg, 0);
        check("mid_rst_c_data", bus.c_writedatain, 0);
        check("mid_rst_count", bus.fifo_count, 0);
        check("mid_rst_l_ready", bus.l_ready, 1'b1);
        check("mid_rst_pend", bus.a_pending, 1'b0);
        idle();
        @(posedge clk);
        #3;
        resetn = 1'b1;
        repeat (4) step();
        check("post_rst_count", bus.fifo_count, 0);
        check("post_rst_we", bus.c_we, 1'b0);

        // Random mixed traffic, exercising pointer wrap and back-pressure
        for (int k = 0; k < 400; k++) begin
            bus.p_we      = ($urandom_range(0, 2) == 0);
            bus.p_squashn = ($urandom_range(0, 3) != 0);
            bus.p_reg     = 5'($urandom_range(0, 7));
            bus.p_data    = $urandom;
            bus.l_valid   = ($urandom_range(0, 1) == 1);
            bus.l_reg     = 5'($urandom_range(0, 7));
            bus.l_data    = $urandom;
            bus.issue_en  = ($urandom_range(0, 3) == 0);
            bus.issue_reg = 5'($urandom_range(0, 31));
            step();
        end
        idle();
        for (int k = 0; k < 20 && m_fifo.size() != 0; k++) step();
        step();
        @(negedge clk);
        #1;
        check("final_model_fifo", m_fifo.size(), 0);
        check("final_exp_q", exp_q.size(), 0);
        check("final_count", bus.fifo_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_writeback_arbiter.md
# reg_writeback_arbiter

Write-side controller for the scalar register file. It merges the in-order pipeline writeback stream and a buffered long-latency return stream (loads, multiply/divide) into the single register-file write port (c_reg / c_writedatain / c_we). It also keeps a per-register pending scoreboard so the issue stage can stall reads of registers with an outstanding long-latency write. It sits between the writeback stage and the register file. Its outputs connect directly to the register file write port.

## Interface
- WIDTH, 32, data width
- NUMREGS, 32, number of architectural registers
- LOG2NUMREGS, 5, register index width
- FIFODEPTH, 4, long-latency return buffer depth (power of two, ≥2)
- LOG2FIFODEPTH, 2, log2 of FIFODEPTH

Clocking and reset (already decided): one clock `clk`; reset `resetn`, asynchronous, active-low.

- clk  in  1  clock
- resetn  in  1  async active-low reset
- p_reg  in  LOG2NUMREGS  pipeline writeback destination
- p_data  in  WIDTH  pipeline writeback data
- p_we  in  1  pipeline writeback request
- p_squashn  in  1  low = pipeline write squashed
- l_reg  in  LOG2NUMREGS  long-latency return destination
- l_data  in  WIDTH  long-latency return data
- l_valid  in  1  return valid
- l_ready  out  1  buffer can accept a return
- issue_reg  in  LOG2NUMREGS  destination of a newly issued long-latency op
- issue_en  in  1  mark issue_reg pending
- a_reg, b_reg  in  LOG2NUMREGS each  source registers being read by issue stage
- a_pending, b_pending  out  1 each  scoreboard bit of a_reg / b_reg (combinational)
- c_reg  out  LOG2NUMREGS  register file write address
- c_writedatain  out  WIDTH  register file write data
- c_we  out  1  register file write enable
- fifo_count  out  LOG2FIFODEPTH+1  buffered return entries
- waw_err  out  1  one-cycle pulse: pipeline write hit a pending register

## Operation
- Pipeline write is accepted when p_we & p_squashn & (p_reg != 0). It always wins the write port and is never stalled.
- Return handshake: transfer on l_valid & l_ready. l_ready = (fifo_count != FIFODEPTH), derived from the registered count only. A pop in the same cycle does not make room for a push in that cycle.
- A transfer with l_reg == 0 is accepted and discarded: it is not enqueued and no scoreboard effect occurs.
- FIFO is circular with read and write pointers that wrap modulo FIFODEPTH. Push and pop in the same cycle leave the count unchanged.
- Arbitration each cycle:
  - If an accepted pipeline write is present: drive it to the write port.
  - Else, if the FIFO is non-empty: pop the head entry and drive it.
  - Else: c_we = 0.
- There is no same-cycle bypass from l_* into the write port. Every return passes through the FIFO.
- Scoreboard: NUMREGS bits; bit 0 is hardwired 0.
  - issue_en sets bit[issue_reg].
  - A FIFO pop schedules a clear of bit[popped reg].
  - If a set and a clear target the same register in the same cycle, the set wins.
- waw_err pulses when an accepted pipeline write targets a register whose scoreboard bit is set. The write is still performed and the scoreboard is unchanged.
- Reset mid-operation: FIFO contents are dropped, pointers and count go to 0, the scoreboard clears, and any in-flight write is lost.

## Timing
- Reset values: c_we 0, c_reg 0, c_writedatain 0, fifo_count 0, waw_err 0, scoreboard all 0. l_ready reads 1 and a_pending/b_pending read 0 (combinational from reset state).
- c_reg, c_writedatain, c_we and waw_err are registered.
- Pipeline write presented in cycle N: c_we is high in N+1.
- Return accepted in cycle N (captured at the edge ending N): the entry is poppable in N+1 and c_we is high at the earliest in N+2.
- A return that loses arbitration stays at the FIFO head and retries every cycle. There is no starvation bound.
- Scoreboard timing:
  - A set from issue_en in cycle N is visible on *_pending in N+1.
  - A clear from a pop in cycle N+1 is visible in N+3, one cycle after c_we.
  - The delayed clear is required because the register file returns OLD_DATA on a same-edge read/write.

## Test plan
- Reset, then p_we=1, p_squashn=1, p_reg=5, p_data=0xDEADBEEF in cycle 1 → c_we=1, c_reg=5, c_writedatain=0xDEADBEEF in cycle 2 only.
- p_reg=0 with p_we=1, or p_squashn=0 with p_reg=7 → c_we stays 0.
- issue_en with issue_reg=9 in cycle 1 → a_pending=1 for a_reg=9 from cycle 2. Return l_reg=9, l_data=0x1234 accepted in cycle 3 with no pipeline writes → c_we and c_reg=9 in cycle 5; a_pending=0 from cycle 6.
- Four returns accepted back-to-back while p_we is held high → fifo_count=4 and l_ready=0. Drop p_we → four writes appear in FIFO order on consecutive cycles, and l_ready=1 the cycle after the first pop.
- Set bit 3, then pipeline write to reg 3 → waw_err pulses one cycle with c_we, and bit 3 remains set.
- Fill the FIFO to 2 entries, then pulse resetn low asynchronously mid-cycle → all outputs return to reset values immediately, and no stale write follows the deassertion.
